// File: rtl/uib_mem_arbiter_if.sv
// UIB point-to-point link: request/address/data toward the slave,
// read data and one-cycle ack back toward the master.
interface uib_mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MODE_WIDTH = 3
);
    logic                  req;
    logic                  wen;
    logic [MODE_WIDTH-1:0] mode;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  ack;

    modport master (
        output req, wen, mode, addr, dat_i,
        input  dat_o, ack
    );

    modport slave (
        input  req, wen, mode, addr, dat_i,
        output dat_o, ack
    );
endinterface

// File: rtl/uib_mem_arbiter.sv
// Two-master UIB arbiter in front of one fixed-latency memory slave.
// Define UIB_ARB_FIXED_PRIO_EN for fixed m0 priority (default: round-robin).
module uib_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MODE_WIDTH = 3,
    parameter int RD_LAT     = 1
) (
    input logic                clk,
    input logic                rst,
    uib_mem_arbiter_if.slave   m0,
    uib_mem_arbiter_if.slave   m1,
    uib_mem_arbiter_if.master  s
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(RD_LAT - 1);

    state_t                state;
    logic                  grant;
    logic [3:0]            cnt;
    logic                  pick1;
    logic                  rsp;
    logic                  s_req_q;
    logic                  s_wen_q;
    logic [MODE_WIDTH-1:0] s_mode_q;
    logic [ADDR_WIDTH-1:0] s_addr_q;
    logic [DATA_WIDTH-1:0] s_dat_q;

`ifdef UIB_ARB_FIXED_PRIO_EN
    // m1 only wins when m0 is not asking
    always_comb begin
        pick1 = m1.req & ~m0.req;
    end
`else
    logic last_grant;

    // on a tie the master that did not win last time goes next
    always_comb begin
        pick1 = m1.req & (~m0.req | ~last_grant);
    end
`endif

    // transaction sequencer; s_* regs double as the request hold regs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            grant    <= 1'b0;
            cnt      <= 4'd0;
            s_req_q  <= 1'b0;
            s_wen_q  <= 1'b0;
            s_mode_q <= '0;
            s_addr_q <= '0;
            s_dat_q  <= '0;
`ifndef UIB_ARB_FIXED_PRIO_EN
            last_grant <= 1'b1;
`endif
        end else begin
            unique case (state)
                IDLE: begin
                    if (m0.req | m1.req) begin
                        grant    <= pick1;
                        s_req_q  <= 1'b1;
                        s_wen_q  <= pick1 ? m1.wen   : m0.wen;
                        s_mode_q <= pick1 ? m1.mode  : m0.mode;
                        s_addr_q <= pick1 ? m1.addr  : m0.addr;
                        s_dat_q  <= pick1 ? m1.dat_i : m0.dat_i;
`ifndef UIB_ARB_FIXED_PRIO_EN
                        last_grant <= pick1;
`endif
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    s_req_q  <= 1'b0;
                    s_wen_q  <= 1'b0;
                    s_mode_q <= '0;
                    s_addr_q <= '0;
                    s_dat_q  <= '0;
                    cnt      <= WAIT_LOAD;
                    state    <= (WAIT_LOAD == 4'd0) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // response path: slave data forwarded to the winner in RESP only
    always_comb begin
        rsp      = (state == RESP);
        m0.ack   = rsp & ~grant;
        m1.ack   = rsp & grant;
        m0.dat_o = (rsp & ~grant) ? s.dat_o : '0;
        m1.dat_o = (rsp & grant) ? s.dat_o : '0;
    end

    assign s.req   = s_req_q;
    assign s.wen   = s_wen_q;
    assign s.mode  = s_mode_q;
    assign s.addr  = s_addr_q;
    assign s.dat_i = s_dat_q;
endmodule

// File: tb/tb_uib_mem_arbiter.sv
// Bench for uib_mem_arbiter: RD_LAT=1 and RD_LAT=3 copies share stimulus,
// checked against a transaction-level reference of grant/issue/ack timing.
module tb_uib_mem_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = 3;
    localparam int LAT_A = 1;
    localparam int LAT_B = 3;
    localparam int RB = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        r0, r1, w0, w1;
    logic [2:0]  md0, md1;
    logic [31:0] ad0, ad1, wd0, wd1;

    uib_mem_arbiter_if #(AW, DW, MW) m0a ();
    uib_mem_arbiter_if #(AW, DW, MW) m1a ();
    uib_mem_arbiter_if #(AW, DW, MW) sa ();
    uib_mem_arbiter_if #(AW, DW, MW) m0b ();
    uib_mem_arbiter_if #(AW, DW, MW) m1b ();
    uib_mem_arbiter_if #(AW, DW, MW) sb ();

    assign {m0a.req, m0a.wen, m0a.mode, m0a.addr, m0a.dat_i} = {r0, w0, md0, ad0, wd0};
    assign {m1a.req, m1a.wen, m1a.mode, m1a.addr, m1a.dat_i} = {r1, w1, md1, ad1, wd1};
    assign {m0b.req, m0b.wen, m0b.mode, m0b.addr, m0b.dat_i} = {r0, w0, md0, ad0, wd0};
    assign {m1b.req, m1b.wen, m1b.mode, m1b.addr, m1b.dat_i} = {r1, w1, md1, ad1, wd1};
    assign sa.ack = 1'b0;
    assign sb.ack = 1'b0;

    uib_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MODE_WIDTH(MW), .RD_LAT(LAT_A)
    ) dut_a (
        .clk(clk), .rst(rst), .m0(m0a), .m1(m1a), .s(sa)
    );

    uib_mem_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MODE_WIDTH(MW), .RD_LAT(LAT_B)
    ) dut_b (
        .clk(clk), .rst(rst), .m0(m0b), .m1(m1b), .s(sb)
    );

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [2:0] m);
        logic [31:0] r;
        r = old;
        if (m[0]) r[7:0] = d[7:0];
        if (m[1]) r[15:8] = d[15:8];
        if (m[2]) r[31:16] = d[31:16];
        return r;
    endfunction

    // fixed-latency memory slaves
    logic [31:0] smem [2][256];
    logic [31:0] pa [16];
    logic [31:0] pb [16];

    always @(posedge clk) begin
        if (sa.req && sa.wen) smem[0][sa.addr[7:0]] <= merge(smem[0][sa.addr[7:0]], sa.dat_i, sa.mode);
        pa[0] <= (sa.req && !sa.wen) ? smem[0][sa.addr[7:0]] : 32'h0;
        for (int i = 1; i < 16; i++) pa[i] <= pa[i-1];
        if (sb.req && sb.wen) smem[1][sb.addr[7:0]] <= merge(smem[1][sb.addr[7:0]], sb.dat_i, sb.mode);
        pb[0] <= (sb.req && !sb.wen) ? smem[1][sb.addr[7:0]] : 32'h0;
        for (int i = 1; i < 16; i++) pb[i] <= pb[i-1];
    end
    assign sa.dat_o = pa[LAT_A-1];
    assign sb.dat_o = pb[LAT_B-1];

    // reference model state (ring buffers indexed by cycle)
    logic [31:0] rmem [2][256];
    logic [68:0] ex_s [2][RB];
    bit          iv [2][RB];
    bit          ig [2][RB];
    bit          iw [2][RB];
    logic [7:0]  ia [2][RB];
    logic [31:0] idt [2][RB];
    logic [2:0]  im [2][RB];
    bit          ea0 [2][RB];
    bit          ea1 [2][RB];
    logic [31:0] ed0 [2][RB];
    logic [31:0] ed1 [2][RB];
    bit          cd0 [2][RB];
    bit          cd1 [2][RB];
    int          nfree [2];
    bit          last [2];
    int          checks, failures, cyc;

    task automatic clr(int d, int k);
        ex_s[d][k] = '0;
        iv[d][k] = 0;
        ea0[d][k] = 0;
        ea1[d][k] = 0;
        ed0[d][k] = '0;
        ed1[d][k] = '0;
        cd0[d][k] = 1;
        cd1[d][k] = 1;
    endtask

    task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, o, e);
        end
    endtask

    task automatic tick();
        logic [68:0] os;
        bit          oa0, oa1;
        logic [31:0] od0, od1, rd;
        int          k, kk, lat, g;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            lat = (d == 0) ? LAT_A : LAT_B;
            k = cyc % RB;
            if (d == 0) begin
                os  = {sa.req, sa.wen, sa.mode, sa.addr, sa.dat_i};
                oa0 = m0a.ack;
                oa1 = m1a.ack;
                od0 = m0a.dat_o;
                od1 = m1a.dat_o;
            end else begin
                os  = {sb.req, sb.wen, sb.mode, sb.addr, sb.dat_i};
                oa0 = m0b.ack;
                oa1 = m1b.ack;
                od0 = m0b.dat_o;
                od1 = m1b.dat_o;
            end
            if (iv[d][k]) begin
                kk = (cyc + lat) % RB;
                if (iw[d][k]) begin
                    rmem[d][ia[d][k]] = merge(rmem[d][ia[d][k]], idt[d][k], im[d][k]);
                    if (ig[d][k]) begin ea1[d][kk] = 1; cd1[d][kk] = 0; end
                    else begin ea0[d][kk] = 1; cd0[d][kk] = 0; end
                end else begin
                    rd = rmem[d][ia[d][k]];
                    if (ig[d][k]) begin ea1[d][kk] = 1; ed1[d][kk] = rd; end
                    else begin ea0[d][kk] = 1; ed0[d][kk] = rd; end
                end
            end
            checks++;
            assert (os === ex_s[d][k]) else begin
                failures++;
                $error("FAIL s_bus dut%0d cyc=%0d observed=%h expected=%h", d, cyc, os, ex_s[d][k]);
            end
            checks++;
            assert ({oa0, oa1} === {ea0[d][k], ea1[d][k]}) else begin
                failures++;
                $error("FAIL acks dut%0d cyc=%0d observed=%b%b expected=%b%b",
                       d, cyc, oa0, oa1, ea0[d][k], ea1[d][k]);
            end
            if (cd0[d][k]) begin
                checks++;
                assert (od0 === ed0[d][k]) else begin
                    failures++;
                    $error("FAIL m0_dat dut%0d cyc=%0d observed=%h expected=%h", d, cyc, od0, ed0[d][k]);
                end
            end
            if (cd1[d][k]) begin
                checks++;
                assert (od1 === ed1[d][k]) else begin
                    failures++;
                    $error("FAIL m1_dat dut%0d cyc=%0d observed=%h expected=%h", d, cyc, od1, ed1[d][k]);
                end
            end
            clr(d, k);
            if (rst) begin
                for (int j = 0; j < RB; j++) clr(d, j);
                nfree[d] = cyc + 1;
                last[d] = 1;
            end else if (cyc >= nfree[d] && (r0 || r1)) begin
`ifdef UIB_ARB_FIXED_PRIO_EN
                g = r0 ? 0 : 1;
`else
                g = (r0 && r1) ? (last[d] ? 0 : 1) : (r0 ? 0 : 1);
`endif
                kk = (cyc + 1) % RB;
                ex_s[d][kk] = g ? {1'b1, w1, md1, ad1, wd1} : {1'b1, w0, md0, ad0, wd0};
                iv[d][kk]  = 1;
                ig[d][kk]  = (g == 1);
                iw[d][kk]  = g ? w1 : w0;
                ia[d][kk]  = g ? ad1[7:0] : ad0[7:0];
                idt[d][kk] = g ? wd1 : wd0;
                im[d][kk]  = g ? md1 : md0;
                nfree[d] = cyc + lat + 2;
                last[d] = (g == 1);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    int got[$];
    int at[$];

    initial begin
        checks = 0;
        failures = 0;
        cyc = 0;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 256; i++) begin
                smem[d][i] = (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
                rmem[d][i] = (i * 32'h9E3779B1) ^ 32'h5A5A5A5A;
            end
            smem[d][8'h10] = 32'hDEADBEEF;
            rmem[d][8'h10] = 32'hDEADBEEF;
            for (int j = 0; j < RB; j++) clr(d, j);
            nfree[d] = 0;
            last[d] = 1;
        end
        for (int i = 0; i < 16; i++) begin pa[i] = '0; pb[i] = '0; end
        rst = 1;
        {r0, r1, w0, w1} = '0;
        {md0, md1} = '0;
        {ad0, ad1, wd0, wd1} = '0;
        @(posedge clk);
        #1;
        chk("rst_sreq", 32'(sa.req), 0);
        chk("rst_m0ack", 32'(m0a.ack), 0);
        chk("rst_m0dat", m0a.dat_o, 0);
        tick();

        // single m0 read
        rst = 0;
        r0 = 1; w0 = 0; md0 = 3'b111; ad0 = 32'h10; wd0 = 32'h0;
        tick();
        chk("t1_sreq", 32'(sa.req), 1);
        chk("t1_saddr", sa.addr, 32'h10);
        chk("t1_swen", 32'(sa.wen), 0);
        chk("t4_b_sreq", 32'(sb.req), 1);
        tick();
        chk("t1_m0ack", 32'(m0a.ack), 1);
        chk("t1_m0dat", m0a.dat_o, 32'hDEADBEEF);
        chk("t1_m1ack", 32'(m1a.ack), 0);
        chk("t4_b_sreq_t2", 32'(sb.req), 0);
        chk("t4_b_ack_t2", 32'(m0b.ack), 0);
        r0 = 0;
        tick();
        chk("t4_b_ack_t3", 32'(m0b.ack), 0);
        tick();
        chk("t4_b_ack_t4", 32'(m0b.ack), 1);
        chk("t4_b_dat_t4", m0b.dat_o, 32'hDEADBEEF);
        tick();

        // both masters hold req after reset
        rst = 1;
        tick();
        rst = 0;
        r0 = 1; r1 = 1; w0 = 0; w1 = 0; ad0 = 32'h04; ad1 = 32'h08;
        for (int i = 0; i < 30 && got.size() < 4; i++) begin
            tick();
            if (m0a.ack) begin got.push_back(0); at.push_back(cyc); end
            if (m1a.ack) begin got.push_back(1); at.push_back(cyc); end
        end
        chk("t2_count", 32'(got.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < got.size()) begin
`ifdef UIB_ARB_FIXED_PRIO_EN
                chk("t2_order", 32'(got[i]), 0);
`else
                chk("t2_order", 32'(got[i]), 32'(i % 2));
`endif
                if (i > 0) chk("t2_gap", 32'(at[i] - at[i-1]), 3);
            end
        end
        r0 = 0; r1 = 0;
        repeat (6) tick();

        // m1 byte write then m0 read-back
        r1 = 1; w1 = 1; md1 = 3'b001; ad1 = 32'h22; wd1 = 32'h000000AB;
        tick();
        chk("t3_swen", 32'(sa.wen), 1);
        chk("t3_smode", 32'(sa.mode), 1);
        tick();
        chk("t3_m1ack", 32'(m1a.ack), 1);
        r1 = 0; w1 = 0;
        repeat (5) tick();
        r0 = 1; w0 = 0; ad0 = 32'h22;
        tick();
        tick();
        chk("t3_rd_ack", 32'(m0a.ack), 1);
        chk("t3_rd_byte0", m0a.dat_o & 32'hFF, 32'hAB);
        r0 = 0;
        repeat (6) tick();

        // reset during ISSUE
        r0 = 1; r1 = 1; w0 = 0; w1 = 0; ad0 = 32'h30; ad1 = 32'h34;
        tick();
`ifdef UIB_ARB_FIXED_PRIO_EN
        chk("t5_pre_addr", sa.addr, 32'h30);
`else
        chk("t5_pre_addr", sa.addr, 32'h34);
`endif
        rst = 1;
        tick();
        chk("t5_sreq", 32'(sa.req), 0);
        chk("t5_m0ack", 32'(m0a.ack), 0);
        chk("t5_m1ack", 32'(m1a.ack), 0);
        rst = 0;
        tick();
        chk("t5_post_sreq", 32'(sa.req), 1);
        chk("t5_post_addr", sa.addr, 32'h30);
        tick();
        chk("t5_post_ack", 32'(m0a.ack), 1);
        r0 = 0; r1 = 0;
        repeat (6) tick();

        // random traffic against the reference
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 39) == 0);
            r0  = ($urandom_range(0, 2) != 0);
            r1  = ($urandom_range(0, 2) != 0);
            w0  = $urandom_range(0, 1) == 1;
            w1  = $urandom_range(0, 1) == 1;
            md0 = 3'($urandom_range(1, 7));
            md1 = 3'($urandom_range(1, 7));
            ad0 = 32'($urandom_range(0, 63));
            ad1 = 32'($urandom_range(0, 63));
            wd0 = $urandom;
            wd1 = $urandom;
            tick();
        end
        rst = 0; r0 = 0; r1 = 0;
        repeat (8) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
